// File: rtl/synapse_current.sv
`default_nettype none
// ============================================================================
// Module      : synapse_current
// Description : Postsynaptic current generator. Delivered presynaptic spikes
//               (after a programmable axonal delay) inject the stored synaptic
//               weight into a saturating current register that decays
//               exponentially on a prescaled tick.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_current #(
  parameter int MAX_DELAY    = 15,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pre_spike,
  input  logic [7:0] weight,
  input  logic       weight_valid,
  input  logic [3:0] delay,
  output logic [7:0] current,
  output logic       psc_active,
  output logic       spike_dropped
);

  localparam int         PW       = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [3:0] MAXD     = 4'(MAX_DELAY);
  localparam logic [PW-1:0] LAST  = PW'(DECAY_PERIOD - 1);

  logic [7:0]           weight_reg;
  logic [3:0]           delay_reg;
  logic [MAX_DELAY-1:0] dl;
  logic [PW-1:0]        presc;

  logic                 decay_tick;
  logic                 d_spike;
  logic [7:0]           step;
  logic [7:0]           c_dec;
  logic [8:0]           sum;
  logic [7:0]           current_next;
  logic [3:0]           delay_clamped;
  logic                 line_empty;
  logic [MAX_DELAY:0]   dl_ext;

  // Decay, delivered-spike selection and saturating injection.
  always_comb begin
    decay_tick = (presc == LAST);
    d_spike    = pre_spike;
    if (delay_reg != 4'd0) begin
      d_spike = dl[delay_reg - 4'd1];
    end
    // Small currents still lose one LSB per tick so they always reach zero.
    step = current >> DECAY_SHIFT;
    if (step == 8'd0 && current != 8'd0) begin
      step = 8'd1;
    end
    c_dec = decay_tick ? (current - step) : current;
    sum   = {1'b0, c_dec} + {1'b0, weight_reg};
    current_next = c_dec;
    if (d_spike) begin
      current_next = sum[8] ? 8'hFF : sum[7:0];
    end
    delay_clamped = (delay > MAXD) ? MAXD : delay;
    // A new delay is only taken when nothing is in flight, so no spike is
    // lost or delivered twice by a tap change.
    line_empty    = (dl == '0) && !pre_spike;
    dl_ext        = {dl, pre_spike};
  end

  // All state advances only on enabled edges; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_reg    <= 8'd0;
      delay_reg     <= 4'd0;
      dl            <= '0;
      presc         <= '0;
      current       <= 8'd0;
      spike_dropped <= 1'b0;
    end else if (en) begin
      dl            <= dl_ext[MAX_DELAY-1:0];
      presc         <= decay_tick ? '0 : presc + 1'b1;
      current       <= current_next;
      spike_dropped <= d_spike & sum[8];
      if (weight_valid) begin
        weight_reg <= weight;
      end
      if (line_empty) begin
        delay_reg <= delay_clamped;
      end
    end else begin
      spike_dropped <= 1'b0;
    end
  end

  assign psc_active = (current != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_synapse_current.sv
`default_nettype none
// ============================================================================
// Module      : tb_synapse_current
// Description : Self-checking bench for synapse_current. A schedule-based
//               reference model predicts current/psc_active/spike_dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse_current;

  localparam int MAX_DELAY    = 15;
  localparam int DECAY_SHIFT  = 3;
  localparam int DECAY_PERIOD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pre_spike = 1'b0;
  logic [7:0] weight = 8'd0;
  logic       weight_valid = 1'b0;
  logic [3:0] delay = 4'd0;
  logic [7:0] current;
  logic       psc_active;
  logic       spike_dropped;

  synapse_current #(
    .MAX_DELAY(MAX_DELAY), .DECAY_SHIFT(DECAY_SHIFT), .DECAY_PERIOD(DECAY_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike),
    .weight(weight), .weight_valid(weight_valid), .delay(delay),
    .current(current), .psc_active(psc_active), .spike_dropped(spike_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;

  // Reference model: injections are scheduled by absolute enabled-edge index.
  int m_cur, m_w, m_dreg, m_pres, m_age, n;
  bit m_drop;
  bit sched [32];

  function automatic void chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cur = 0; m_w = 0; m_dreg = 0; m_pres = 0; m_age = 100; n = 0; m_drop = 0;
    for (int i = 0; i < 32; i++) sched[i] = 0;
  endfunction

  function automatic void model_step(bit e, bit ps, bit wv, int w, int d);
    int cp, dec, sum, age_now;
    bit tick, ds;
    if (!e) begin
      m_drop = 0;
      return;
    end
    tick   = (m_pres == DECAY_PERIOD - 1);
    m_pres = tick ? 0 : m_pres + 1;
    cp = m_cur;
    if (tick && cp > 0) begin
      dec = cp >> DECAY_SHIFT;
      if (dec == 0) dec = 1;
      cp = cp - dec;
    end
    ds = sched[n % 32];
    sched[n % 32] = 0;
    if (ps) begin
      if (m_dreg == 0) ds = 1;
      else sched[(n + m_dreg) % 32] = 1;
    end
    sum    = ds ? cp + m_w : cp;
    m_drop = (sum > 255);
    m_cur  = (sum > 255) ? 255 : sum;
    // Line is empty once the last spike has shifted past the last tap.
    age_now = (m_age >= 100) ? 100 : m_age + 1;
    if (!ps && age_now > MAX_DELAY) m_dreg = (d > MAX_DELAY) ? MAX_DELAY : d;
    m_age = ps ? 0 : age_now;
    if (wv) m_w = w;
    n++;
  endfunction

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (run) begin
      chk("current", current, m_cur);
      chk("psc_active", psc_active, (m_cur != 0) ? 1 : 0);
      chk("spike_dropped", spike_dropped, m_drop);
    end
  end

  task automatic cyc(bit e, bit ps, bit wv, logic [7:0] w, logic [3:0] d);
    @(negedge clk);
    en = e; pre_spike = ps; weight_valid = wv; weight = w; delay = d;
    @(posedge clk);
    if (rst_n) model_step(e, ps, wv, w, d);
    #2;
  endtask

  task automatic idle(int cycles, logic [3:0] d);
    for (int i = 0; i < cycles; i++) cyc(1'b1, 1'b0, 1'b0, 8'd0, d);
  endtask

  task automatic do_reset();
    en = 1'b0; pre_spike = 1'b0; weight_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_current", current, 0);
    chk("reset_psc_active", psc_active, 0);
    chk("reset_spike_dropped", spike_dropped, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v;
    model_reset();
    #12;
    do_reset();
    run = 1'b1;

    // Weight 100, delay 0, spike on edge 10, then two decay steps.
    cyc(1, 0, 1, 8'd100, 4'd0);
    idle(8, 4'd0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    chk("inject_100", current, 100);
    for (int i = 0; i < 8 && current == 8'd100; i++) idle(1, 4'd0);
    chk("decay_88", current, 88);
    for (int i = 0; i < 8 && current == 8'd88; i++) idle(1, 4'd0);
    chk("decay_77", current, 77);

    // Delay 3: current unchanged for three edges, injected on the third.
    do_reset();
    cyc(1, 0, 1, 8'd50, 4'd3);
    cyc(1, 1, 0, 8'd0, 4'd3);
    chk("dly3_k", current, 0);
    idle(1, 4'd3); chk("dly3_k1", current, 0);
    idle(1, 4'd3); chk("dly3_k2", current, 0);
    idle(1, 4'd3); chk("dly3_k3", current, 50);

    // Saturation with back-to-back spikes.
    do_reset();
    cyc(1, 0, 1, 8'd200, 4'd0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    chk("sat_first", current, 200);
    chk("sat_first_drop", spike_dropped, 0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    chk("sat_second", current, 255);
    chk("sat_drop", spike_dropped, 1);
    idle(1, 4'd0);
    chk("sat_drop_clear", spike_dropped, 0);

    // Small current decays by one per tick (ticks on edges 4,8,...,20).
    do_reset();
    cyc(1, 0, 1, 8'd5, 4'd0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    chk("small_5", current, 5);
    idle(17, 4'd0);
    chk("small_1", current, 1);
    idle(1, 4'd0);
    chk("small_0", current, 0);
    chk("small_psc_off", psc_active, 0);

    // Delay change while a spike is in flight.
    do_reset();
    cyc(1, 0, 1, 8'd40, 4'd3);
    cyc(1, 1, 0, 8'd0, 4'd0);
    idle(1, 4'd0); chk("chg_k1", current, 0);
    idle(1, 4'd0); chk("chg_k2", current, 0);
    idle(1, 4'd0); chk("chg_k3", current, 40);
    idle(16, 4'd0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    idle(4, 4'd0);

    // Asynchronous reset with current 150 and a spike in the line.
    do_reset();
    cyc(1, 0, 1, 8'd150, 4'd3);
    cyc(1, 1, 0, 8'd0, 4'd3);
    idle(3, 4'd3);
    chk("pre_rst_150", current, 150);
    cyc(1, 1, 0, 8'd0, 4'd3);
    idle(1, 4'd3);
    do_reset();
    idle(6, 4'd3);
    chk("post_rst_quiet", current, 0);

    // en low freezes everything; pulses and weight loads are ignored.
    do_reset();
    cyc(1, 0, 1, 8'd60, 4'd0);
    cyc(1, 1, 0, 8'd0, 4'd0);
    v = current;
    for (int i = 0; i < 10; i++) cyc(0, i[0], 1, 8'd200, 4'd5);
    chk("freeze_hold", current, v);
    cyc(1, 1, 0, 8'd0, 4'd0);
    idle(5, 4'd0);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
            $urandom_range(0, 9) == 0, 8'($urandom), 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
